decode_ctrl_pipe: RTL and testbench
===================================

# decode_ctrl_pipe

Registered RV32I decode/control stage that sits between instruction fetch and execute. It turns a fetched instruction into a registered control bundle: enables, ALU op, register indices and sign-extended immediate. It detects load-use hazards and inserts one bubble for each, accepts a flush from branch resolution, and flags illegal encodings. Optional M-extension decode and a saturating stall counter are selected by parameter.

## Interface
- `M_EXT`, default 0: 1 = decode OP funct7=0000001 as MUL (alu_op 10); 0 = such encodings are illegal.
- `HAZARD_EN`, default 1: 1 = load-use detection active; 0 = hazard is forced to 0.
- `CNT_W`, default 16: width of the stall counter.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the instruction from fetch is valid.
- `in_instr` in 32: the fetched instruction.
- `in_ready` out 1: the stage accepts `in_instr` this cycle.
- `flush` in 1: branch/jump redirect; kills the output register and the current input.
- `out_valid` out 1: the control bundle is valid.
- `out_ready` in 1: execute consumes the bundle.
- `out_wr_en`, `out_lw_en`, `out_sw_en`, `out_sub_en`, `out_jal_en`, `out_jalr_en`, `out_br_en` out 1 each: control enables.
- `out_alu_op` out 4: ALU operation code.
- `out_funct3` out 3: funct3 passthrough, used for branch compare and load/store size.
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: register indices.
- `out_imm` out 32: sign-extended immediate.
- `out_illegal` out 1: the instruction is not recognised.
- `stall_cnt` out CNT_W: saturating count of hazard bubbles inserted.

## Operation
- Opcodes decoded:
  - LUI 0110111
  - AUIPC 0010111
  - JAL 1101111
  - JALR 1100111
  - BRANCH 1100011
  - LOAD 0000011
  - STORE 0100011
  - OP-IMM 0010011
  - OP 0110011
- Any other opcode gives illegal=1 with every enable 0.
- `wr_en` = opcode ∈ {LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP} AND rd≠0 AND not illegal.
- Single-bit enables:
  - `lw_en` = LOAD.
  - `sw_en` = STORE.
  - `jal_en` = JAL.
  - `jalr_en` = JALR.
  - `br_en` = BRANCH.
  - `sub_en` = OP with funct3=000 and funct7=0100000.
- `alu_op` encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 PASS_B.
  - LUI uses PASS_B.
  - AUIPC, loads, stores, JAL, JALR and branches use ADD.
  - OP-IMM follows funct3; SRAI is selected by instr[30].
- OP with funct7 ∉ {0000000, 0100000, 0000001 (M_EXT only)} is illegal.
- Immediates, sign-extended from instr[31]:
  - I for OP-IMM, LOAD and JALR.
  - S for STORE.
  - B for BRANCH.
  - U for LUI and AUIPC.
  - J for JAL.
  - 0 for OP.
- Source usage:
  - rs1 is used by all types except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH.
- Hazard condition: HAZARD_EN AND out_valid AND out_lw_en AND out_rd≠0 AND in_valid AND ((uses_rs1 AND rs1==out_rd) OR (uses_rs2 AND rs2==out_rd)).
- `in_ready` = !flush AND (!out_valid OR out_ready) AND !hazard.
- Output register update, evaluated every cycle in this priority order:
  1. If `flush`: out_valid←0.
  2. Else if (!out_valid OR out_ready):
     - in_valid AND !hazard → load the decoded bundle, out_valid←1.
     - otherwise → out_valid←0, a bubble.
  3. Else: hold every output unchanged.
- Stall counter: `stall_cnt` increments when hazard AND (!out_valid OR out_ready) AND !flush. It saturates at all-ones.
- Illegal instructions are still passed with out_valid=1 and out_illegal=1; the trap is handled downstream.

## Timing
- Reset (rst_n=0, asynchronous): every `out_*` is 0, including out_valid, out_illegal and out_imm; stall_cnt=0.
- `in_ready` is combinational from flush, out_valid, out_ready and the hazard term. It is 1 immediately after reset.
- Latency is one cycle: an instruction accepted at edge N is presented with out_valid=1 from edge N+1.
- Throughput is one instruction per cycle when there is no hazard, no flush and out_ready=1.
- Load-use costs exactly one bubble:
  - The dependent instruction sees in_ready=0 for one cycle.
  - It is accepted in the next cycle, because the load has left the output register.
- Back-pressure: with out_valid=1 and out_ready=0, the bundle holds bit-stable and in_ready=0.
- A flush in the same cycle as in_valid=1 discards the input (in_ready=0). out_valid is 0 on the next cycle.
- Reset asserted mid-stall clears state at once. No pending bubble survives reset.

## Test plan
- Reset → all outputs 0 and in_ready=1. Then `addi x1,x0,5` (0x00500093) → one cycle later out_valid=1, wr_en=1, alu_op=0, rd=1, imm=5.
- `sub x3,x1,x2` (0x402081B3) → sub_en=1, alu_op=1, wr_en=1. `add x0,x1,x2` → wr_en=0.
- `lw x5,0(x1)` followed by `add x6,x5,x0`:
  - in_ready=0 for one cycle; one bubble with out_valid=0; stall_cnt=1; the add then issues.
  - With HAZARD_EN=0: no bubble, stall_cnt stays 0.
- `mul x1,x2,x3` (0x023100B3):
  - M_EXT=0 → out_illegal=1, all enables 0.
  - M_EXT=1 → alu_op=10, wr_en=1.
- out_ready held 0 for 3 cycles with a valid `jal x1,-4` (0xFFDFF0EF) → bundle stable with imm=0xFFFFFFFC and jal_en=1; in_ready=0 throughout.
- flush asserted with in_valid=1 while the output is valid → next cycle out_valid=0, the input is not consumed, and re-presenting the input is accepted normally.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// RV32I decode/control stage: turns a fetched instruction into a registered control bundle,
// inserts one bubble per load-use hazard, honours flush and flags illegal encodings.
module decode_ctrl_pipe #(
    parameter int unsigned M_EXT     = 0,
    parameter int unsigned HAZARD_EN = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_wr_en,
    output logic             out_lw_en,
    output logic             out_sw_en,
    output logic             out_sub_en,
    output logic             out_jal_en,
    output logic             out_jalr_en,
    output logic             out_br_en,
    output logic [3:0]       out_alu_op,
    output logic [2:0]       out_funct3,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [31:0]      out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_MUL    = 4'd10,
        ALU_PASS_B = 4'd11
    } alu_op_e;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic        d_writes;
    logic        d_wr_en;
    logic        d_lw_en;
    logic        d_sw_en;
    logic        d_sub_en;
    logic        d_jal_en;
    logic        d_jalr_en;
    logic        d_br_en;
    logic        d_illegal;
    alu_op_e     d_alu_op;
    logic [31:0] d_imm;
    logic        uses_rs1;
    logic        uses_rs2;

    logic        hazard;
    logic        advance;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    // Shared by OP-IMM and OP; alt selects SRA over SRL (instr[30]).
    function automatic alu_op_e f3_alu(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        d_writes  = 1'b0;
        d_lw_en   = 1'b0;
        d_sw_en   = 1'b0;
        d_sub_en  = 1'b0;
        d_jal_en  = 1'b0;
        d_jalr_en = 1'b0;
        d_br_en   = 1'b0;
        d_illegal = 1'b0;
        d_alu_op  = ALU_ADD;
        d_imm     = '0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_writes = 1'b1;
                d_alu_op = ALU_PASS_B;
                d_imm    = imm_u;
            end
            OPC_AUIPC: begin
                d_writes = 1'b1;
                d_imm    = imm_u;
            end
            OPC_JAL: begin
                d_writes = 1'b1;
                d_jal_en = 1'b1;
                d_imm    = imm_j;
            end
            OPC_JALR: begin
                d_writes  = 1'b1;
                d_jalr_en = 1'b1;
                d_imm     = imm_i;
                uses_rs1  = 1'b1;
            end
            OPC_BRANCH: begin
                d_br_en  = 1'b1;
                d_imm    = imm_b;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                d_writes = 1'b1;
                d_lw_en  = 1'b1;
                d_imm    = imm_i;
                uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                d_sw_en  = 1'b1;
                d_imm    = imm_s;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                d_writes = 1'b1;
                d_alu_op = f3_alu(funct3, in_instr[30]);
                d_imm    = imm_i;
                uses_rs1 = 1'b1;
            end
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (funct7 == 7'b0000000) begin
                    d_writes = 1'b1;
                    d_alu_op = f3_alu(funct3, 1'b0);
                end else if (funct7 == 7'b0100000) begin
                    d_writes = 1'b1;
                    if (funct3 == 3'b000) begin
                        d_sub_en = 1'b1;
                        d_alu_op = ALU_SUB;
                    end else begin
                        d_alu_op = f3_alu(funct3, 1'b1);
                    end
                end else if (funct7 == 7'b0000001 && M_EXT != 0) begin
                    d_writes = 1'b1;
                    d_alu_op = ALU_MUL;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            default: d_illegal = 1'b1;
        endcase
        d_wr_en = d_writes && (rd != '0) && !d_illegal;
    end

    assign hazard = (HAZARD_EN != 0) && out_valid && out_lw_en && (out_rd != '0) && in_valid
                    && ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd));

    assign advance  = !out_valid || out_ready;
    assign in_ready = !flush && advance && !hazard;

    // Flush and bubbles only drop out_valid; the payload is don't-care until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_wr_en   <= 1'b0;
            out_lw_en   <= 1'b0;
            out_sw_en   <= 1'b0;
            out_sub_en  <= 1'b0;
            out_jal_en  <= 1'b0;
            out_jalr_en <= 1'b0;
            out_br_en   <= 1'b0;
            out_alu_op  <= '0;
            out_funct3  <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            if (in_valid && !hazard) begin
                out_valid   <= 1'b1;
                out_wr_en   <= d_wr_en;
                out_lw_en   <= d_lw_en;
                out_sw_en   <= d_sw_en;
                out_sub_en  <= d_sub_en;
                out_jal_en  <= d_jal_en;
                out_jalr_en <= d_jalr_en;
                out_br_en   <= d_br_en;
                out_alu_op  <= d_alu_op;
                out_funct3  <= funct3;
                out_rd      <= rd;
                out_rs1     <= rs1;
                out_rs2     <= rs2;
                out_imm     <= d_imm;
                out_illegal <= d_illegal;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hazard && advance && !flush && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe: a reference decoder queues expected bundles at
// acceptance and compares them when execute consumes the bundle.
module tb_decode_ctrl_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_wr_en, out_lw_en, out_sw_en, out_sub_en;
    logic        out_jal_en, out_jalr_en, out_br_en, out_illegal;
    logic [3:0]  out_alu_op;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic [15:0] stall_cnt;

    logic        alt_in_valid;
    logic [31:0] alt_in_instr;
    logic        alt_in_ready;
    logic        alt_flush;
    logic        alt_out_valid;
    logic        alt_out_ready;
    logic        alt_wr_en, alt_lw_en, alt_sw_en, alt_sub_en;
    logic        alt_jal_en, alt_jalr_en, alt_br_en, alt_illegal;
    logic [3:0]  alt_alu_op;
    logic [2:0]  alt_funct3;
    logic [4:0]  alt_rd, alt_rs1, alt_rs2;
    logic [31:0] alt_imm;
    logic [15:0] alt_stall_cnt;

    typedef struct packed {
        logic [29:0] ctrl;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_ADDX0 = 32'h00208033;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_ADDDP = 32'h00028333;
    localparam logic [31:0] I_MUL   = 32'h023100B3;
    localparam logic [31:0] I_JAL   = 32'hFFDFF0EF;

    decode_ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_wr_en(out_wr_en), .out_lw_en(out_lw_en), .out_sw_en(out_sw_en),
        .out_sub_en(out_sub_en), .out_jal_en(out_jal_en), .out_jalr_en(out_jalr_en),
        .out_br_en(out_br_en), .out_alu_op(out_alu_op), .out_funct3(out_funct3),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    decode_ctrl_pipe #(.M_EXT(1), .HAZARD_EN(0), .CNT_W(16)) alt_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(alt_in_valid), .in_instr(alt_in_instr),
        .in_ready(alt_in_ready), .flush(alt_flush), .out_valid(alt_out_valid),
        .out_ready(alt_out_ready), .out_wr_en(alt_wr_en), .out_lw_en(alt_lw_en),
        .out_sw_en(alt_sw_en), .out_sub_en(alt_sub_en), .out_jal_en(alt_jal_en),
        .out_jalr_en(alt_jalr_en), .out_br_en(alt_br_en), .out_alu_op(alt_alu_op),
        .out_funct3(alt_funct3), .out_rd(alt_rd), .out_rs1(alt_rs1), .out_rs2(alt_rs2),
        .out_imm(alt_imm), .out_illegal(alt_illegal), .stall_cnt(alt_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent reference decoder.
    function automatic exp_t model(input logic [31:0] ins, input bit mext);
        logic wr, lw, sw, sb_en, jal, jalr, br, ill;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        exp_t r;
        wr = 0; lw = 0; sw = 0; sb_en = 0; jal = 0; jalr = 0; br = 0; ill = 0;
        alu = 4'd0; imm = 32'd0;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h37: begin wr = 1; alu = 4'd11; imm = {ins[31:12], 12'd0}; end
            7'h17: begin wr = 1; imm = {ins[31:12], 12'd0}; end
            7'h6F: begin wr = 1; jal = 1;
                         imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
            7'h67: begin wr = 1; jalr = 1; imm = {{21{ins[31]}}, ins[30:20]}; end
            7'h63: begin br = 1;
                         imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
            7'h03: begin wr = 1; lw = 1; imm = {{21{ins[31]}}, ins[30:20]}; end
            7'h23: begin sw = 1; imm = {{21{ins[31]}}, ins[30:25], ins[11:7]}; end
            7'h13, 7'h33: begin
                if (ins[6:0] == 7'h13) imm = {{21{ins[31]}}, ins[30:20]};
                if (ins[6:0] == 7'h33 && !(f7 == 7'h00 || f7 == 7'h20 || (f7 == 7'h01 && mext)))
                    ill = 1;
                else begin
                    wr = 1;
                    case (f3)
                        3'd0: alu = 4'd0;
                        3'd1: alu = 4'd2;
                        3'd2: alu = 4'd3;
                        3'd3: alu = 4'd4;
                        3'd4: alu = 4'd5;
                        3'd5: alu = ins[30] ? 4'd7 : 4'd6;
                        3'd6: alu = 4'd8;
                        default: alu = 4'd9;
                    endcase
                    if (ins[6:0] == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
                        sb_en = 1; alu = 4'd1;
                    end
                    if (ins[6:0] == 7'h33 && f7 == 7'h01) alu = 4'd10;
                end
            end
            default: ill = 1;
        endcase
        if (ins[11:7] == 5'd0) wr = 0;
        r.ctrl = {wr, lw, sw, sb_en, jal, jalr, br, ill, alu, f3,
                  ins[11:7], ins[19:15], ins[24:20]};
        r.imm  = imm;
        return r;
    endfunction

    // Scoreboard monitor: inputs settle 1 time unit after each rising edge, so the
    // falling edge sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && (flush || out_ready)) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (!flush) begin
                        check("sb_ctrl", {out_wr_en, out_lw_en, out_sw_en, out_sub_en,
                              out_jal_en, out_jalr_en, out_br_en, out_illegal, out_alu_op,
                              out_funct3, out_rd, out_rs1, out_rs2}, e.ctrl);
                        check("sb_imm", out_imm, e.imm);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_instr, 1'b0));
        end
    end

    task automatic send(input logic [31:0] ins);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tbl[14];
    int          start;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{32'h123453B7, 32'hFFFFF117, 32'hFE208CE3, 32'h0050A623, 32'hFFF1E213,
                32'h4032D313, 32'h00A49433, 32'h00D625B3, 32'h010280E7, 32'hFFFFFFFF,
                32'h04208033, I_MUL, 32'h4020D1B3, 32'h00F0F093};
        rst_n = 0; in_valid = 0; in_instr = '0; flush = 0; out_ready = 1;
        alt_in_valid = 0; alt_in_instr = '0; alt_flush = 0; alt_out_ready = 1;

        #12;
        check("rst_valid", out_valid, 0);
        check("rst_ctrl", {out_wr_en, out_lw_en, out_sw_en, out_sub_en, out_jal_en,
              out_jalr_en, out_br_en, out_illegal, out_alu_op, out_funct3, out_rd,
              out_rs1, out_rs2}, 0);
        check("rst_imm", out_imm, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        #1 rst_n = 1;
        tick();

        send(I_ADDI);
        @(negedge clk);
        check("addi_valid", out_valid, 1);
        check("addi_fields", {out_wr_en, out_alu_op, out_rd}, {1'b1, 4'd0, 5'd1});
        check("addi_imm", out_imm, 5);
        tick();

        send(I_SUB);
        @(negedge clk);
        check("sub_fields", {out_sub_en, out_alu_op, out_wr_en}, {1'b1, 4'd1, 1'b1});
        tick();
        send(I_ADDX0);
        @(negedge clk);
        check("add_x0_wr", out_wr_en, 0);
        tick();

        start = cyc;
        foreach (tbl[i]) send(tbl[i]);
        check("throughput_cycles", cyc - start, 14);
        send(I_MUL);
        @(negedge clk);
        check("mul_illegal", out_illegal, 1);
        check("mul_enables", {out_wr_en, out_lw_en, out_sw_en, out_sub_en, out_jal_en,
              out_jalr_en, out_br_en}, 0);
        tick();

        // Load-use: one bubble, then the dependent add issues.
        send(I_LW);
        in_valid = 1; in_instr = I_ADDDP;
        @(negedge clk);
        check("lu_in_ready", in_ready, 0);
        check("lu_stall_before", stall_cnt, 0);
        tick();
        @(negedge clk);
        check("lu_bubble", out_valid, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_retry_ready", in_ready, 1);
        tick();
        in_valid = 0;
        @(negedge clk);
        check("lu_add_issued", {out_valid, out_rd}, {1'b1, 5'd6});
        tick();
        tick();

        // Back-pressure with a JAL held for three cycles.
        out_ready = 0;
        send(I_JAL);
        in_valid = 1; in_instr = I_ADDI;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid_jal", {out_valid, out_jal_en}, 2'b11);
            check("bp_imm", out_imm, 32'hFFFFFFFC);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1;
        tick();
        in_valid = 0;

        // Flush while the output holds a valid bundle.
        out_ready = 0;
        in_valid = 1; in_instr = I_SUB; flush = 1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 0;
        @(negedge clk);
        check("flush_killed", out_valid, 0);
        check("flush_reaccept", in_ready, 1);
        tick();
        in_valid = 0; out_ready = 1;
        tick();
        tick();

        // Reset during a pending load-use stall.
        send(I_LW);
        in_valid = 1; in_instr = I_ADDDP;
        @(negedge clk);
        check("rs_stalled", in_ready, 0);
        #1 rst_n = 0; in_valid = 0;
        #1;
        check("rs_valid", out_valid, 0);
        check("rs_lw_rd", {out_lw_en, out_rd}, 0);
        check("rs_stall_cnt", stall_cnt, 0);
        check("rs_in_ready", in_ready, 1);
        sb.delete();
        tick();
        @(negedge clk);
        rst_n = 1;
        tick();
        @(negedge clk);
        check("rs_no_bubble_valid", out_valid, 0);
        check("rs_no_bubble_cnt", stall_cnt, 0);
        tick();

        // M_EXT=1, HAZARD_EN=0 instance: no stall on load-use, MUL decodes.
        alt_in_valid = 1; alt_in_instr = I_LW;
        @(negedge clk);
        check("alt_lw_ready", alt_in_ready, 1);
        tick();
        alt_in_instr = I_ADDDP;
        @(negedge clk);
        check("alt_nohz_ready", alt_in_ready, 1);
        check("alt_lw_out", {alt_out_valid, alt_lw_en, alt_rd}, {1'b1, 1'b1, 5'd5});
        tick();
        alt_in_instr = I_MUL;
        @(negedge clk);
        check("alt_add_out", {alt_out_valid, alt_rd}, {1'b1, 5'd6});
        tick();
        alt_in_valid = 0;
        @(negedge clk);
        check("alt_mul", {alt_out_valid, alt_illegal, alt_alu_op, alt_wr_en},
              {1'b1, 1'b0, 4'd10, 1'b1});
        check("alt_stall_cnt", alt_stall_cnt, 0);
        tick();

        tick();
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
